ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL: clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL: WB_i  in  2  [0]=RegWrite, [1]=MemtoReg; MEM_i  in  3  [0]=MemRead, [1]=MemWrite, [2]=Branch.
REQ-004 SHALL: ALUSrc_i  in  1  selects IMM_i as operand B; ALUOp_i  in  2  00=ADD, 01=SUB, 10=R-type decode, 11=I-type decode.
REQ-005 SHALL: funct_i  in  10  {funct7, funct3} of the instruction in EX.
REQ-006 SHALL: RS1_i, RS2_i, IMM_i  in  32 each; RS1addr_i, RS2addr_i, RDaddr_i  in  5 each.
REQ-007 SHALL: MEMWB_RegWrite_i  in  1; MEMWB_RDaddr_i  in  5; MEMWB_data_i  in  32: writeback-stage forwarding source.
REQ-008 SHALL: flush_i  in  1  kills the instruction currently in EX.
REQ-009 SHALL: WB_o  out  2; MEM_o  out  3; ALUres_o  out  32; MemData_o  out  32 (forwarded RS2); RDaddr_o  out  5: registered EX/MEM outputs.
REQ-010 SHALL: stall_o  out  1  combinational; high freezes PC, IF/ID and ID/EX.

Function
REQ-011 SHALL: forward operand A = EX/MEM ALUres_o when WB_o[0] && RDaddr_o!=0 && RDaddr_o==RS1addr_i && !MEM_o[0]; else MEMWB_data_i when MEMWB_RegWrite_i && MEMWB_RDaddr_i!=0 && match; else RS1_i. Operand B-register likewise with RS2addr_i/RS2_i; EX/MEM source wins over MEM/WB.
REQ-012 SHALL: MemData_o capture the forwarded RS2 value, never IMM_i.
REQ-013 SHALL: decode ALUOp 10: funct {0000000,000}=ADD, {0100000,000}=SUB, {0000000,111}=AND, {0000000,110}=OR, {0000000,100}=XOR, {0000000,001}=SLL, {0000001,000}=MUL; ALUOp 11: funct3 000=ADD, funct3 101 with funct7 0100000=SRA by IMM_i[4:0]; unlisted codes = ADD.
REQ-014 SHALL: all arithmetic be 32-bit two's complement, wrap on overflow; SLL/SRA use B[4:0]; MUL returns low 32 bits of product.
REQ-015 SHALL: non-MUL ops complete in one cycle: EX/MEM registers load result at the next edge.
REQ-016 SHALL: MUL use FSM IDLE->BUSY->DONE->IDLE; in IDLE with MUL decoded and flush_i=0: latch forwarded operands, counter=0, stall_o=1, go BUSY.
REQ-017 SHALL: BUSY run one shift-add step per cycle for 32 cycles (counter 0..31), stall_o=1, EX/MEM load a bubble (WB_o=0, MEM_o=0) each cycle; counter==31 -> DONE.
REQ-018 SHALL: DONE drive stall_o=0, load the product into ALUres_o with the MUL's WB/MEM/RDaddr, return to IDLE; total 34 cycles from MUL presentation to capture.
REQ-019 SHALL: flush_i=1 load a bubble into EX/MEM at the next edge; in BUSY or DONE it aborts the multiply (-> IDLE, stall_o=0 that cycle); flush_i with a MUL in IDLE starts no multiply.
REQ-020 SHALL: a MUL presented in the cycle after DONE start a new multiply normally (back-to-back).

Reset
REQ-021 SHALL: rst_i=1 at an edge set WB_o=0, MEM_o=0, ALUres_o=0, MemData_o=0, RDaddr_o=0, FSM=IDLE, counter=0, stall_o=0 (combinational from IDLE), overriding all other inputs including mid-multiply.

Structure
REQ-022 SHALL: shared package hold ALU-op enum, FSM state enum, WB/MEM control-bit index constants, ALUOp encodings.
REQ-023 SHALL: iterative multiplier be sub-module mul_iter (start, operands, busy, done, 32-bit product); forwarding, ALU, control and EX/MEM register reside in ex_mem_stage.

Verification
REQ-024 SHALL: ADD R-type RS1_i=5, RS2_i=7, no hazards -> next edge ALUres_o=12, WB_o/RDaddr_o passed through.
REQ-025 SHALL: back-to-back dependency (x3=1+2, then x4=x3+10 with RS1_i stale 0) -> second ALUres_o=13 via EX/MEM forward; with MEMWB also matching x3=99, still 13.
REQ-026 SHALL: MUL 0xFFFFFFFF*3 -> stall_o high 33 cycles, bubbles in EX/MEM, then ALUres_o=0xFFFFFFFD on cycle 34 edge.
REQ-027 SHALL: flush_i at BUSY counter 10 -> stall_o low same cycle, WB_o=0/MEM_o=0 next edge, following ADD unaffected.
REQ-028 SHALL: rst_i asserted mid-multiply -> all outputs 0, stall_o=0 next cycle; SRA 0x80000000 by IMM 4 afterwards -> 0xF8000000.
REQ-029 SHALL: load in EX/MEM (MEM_o[0]=1) targeting RS1addr_i -> no EX/MEM forward, operand taken from MEM/WB or RS1_i.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared types and constants for the EX stage and EX/MEM pipeline register.
// Also holds the decode from ALUOp/funct to an ALU operation.
package ex_mem_stage_pkg;

  typedef enum logic [2:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSra, AluMul
  } alu_op_e;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;

  localparam int unsigned WbRegWrite = 0;
  localparam int unsigned WbMemToReg = 1;
  localparam int unsigned MemRead    = 0;
  localparam int unsigned MemWrite   = 1;
  localparam int unsigned MemBranch  = 2;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpRType = 2'b10;
  localparam logic [1:0] AluOpIType = 2'b11;

  // funct is {funct7, funct3}; any unlisted code falls back to ADD.
  function automatic alu_op_e alu_decode(input logic [1:0] alu_op, input logic [9:0] funct);
    alu_op_e op;
    op = AluAdd;
    case (alu_op)
      AluOpSub: op = AluSub;
      AluOpRType: begin
        case (funct)
          10'b0100000_000: op = AluSub;
          10'b0000000_111: op = AluAnd;
          10'b0000000_110: op = AluOr;
          10'b0000000_100: op = AluXor;
          10'b0000000_001: op = AluSll;
          10'b0000001_000: op = AluMul;
          default:         op = AluAdd;
        endcase
      end
      AluOpIType: begin
        if (funct[2:0] == 3'b101 && funct[9:3] == 7'b0100000) op = AluSra;
      end
      default: op = AluAdd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_mem_stage_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle over 32 cycles,
// followed by a single DONE cycle presenting the low 32 bits of the product.
module mul_iter
  import ex_mem_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o
);

  mul_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          mcand_d  = a_i;
          mplier_d = b_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (abort_i) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign busy_o    = (state_q == StBusy);
  assign done_o    = (state_q == StDone);
  assign product_o = acc_q;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding, single-cycle ALU, iterative multiply
// with pipeline stall, and the EX/MEM pipeline register.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  WB_i,
  input  logic [2:0]  MEM_i,
  input  logic        ALUSrc_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [9:0]  funct_i,
  input  logic [31:0] RS1_i,
  input  logic [31:0] RS2_i,
  input  logic [31:0] IMM_i,
  input  logic [4:0]  RS1addr_i,
  input  logic [4:0]  RS2addr_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        MEMWB_RegWrite_i,
  input  logic [4:0]  MEMWB_RDaddr_i,
  input  logic [31:0] MEMWB_data_i,
  input  logic        flush_i,
  output logic [1:0]  WB_o,
  output logic [2:0]  MEM_o,
  output logic [31:0] ALUres_o,
  output logic [31:0] MemData_o,
  output logic [4:0]  RDaddr_o,
  output logic        stall_o
);

  logic [1:0]  wb_q, wb_d;
  logic [2:0]  mem_q, mem_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] md_q, md_d;
  logic [4:0]  rd_q, rd_d;

  // Control of the multiply in flight, held while EX/MEM carries bubbles.
  logic [1:0]  mul_wb_q, mul_wb_d;
  logic [2:0]  mul_mem_q, mul_mem_d;
  logic [4:0]  mul_rd_q, mul_rd_d;
  logic [31:0] mul_md_q, mul_md_d;

  logic [31:0] op_a, fwd_b, op_b, alu_res, product;
  logic        exmem_fwd_ok, mul_busy, mul_done, mul_idle, is_mul, mul_start;
  alu_op_e     alu_op;

  // A load's EX/MEM result is an address, not the loaded data, so it is not forwarded.
  assign exmem_fwd_ok = wb_q[WbRegWrite] && (rd_q != 5'd0) && !mem_q[MemRead];

  always_comb begin
    op_a = RS1_i;
    if (exmem_fwd_ok && rd_q == RS1addr_i) begin
      op_a = alu_q;
    end else if (MEMWB_RegWrite_i && MEMWB_RDaddr_i != 5'd0 && MEMWB_RDaddr_i == RS1addr_i) begin
      op_a = MEMWB_data_i;
    end
    fwd_b = RS2_i;
    if (exmem_fwd_ok && rd_q == RS2addr_i) begin
      fwd_b = alu_q;
    end else if (MEMWB_RegWrite_i && MEMWB_RDaddr_i != 5'd0 && MEMWB_RDaddr_i == RS2addr_i) begin
      fwd_b = MEMWB_data_i;
    end
  end

  assign op_b      = ALUSrc_i ? IMM_i : fwd_b;
  assign alu_op    = alu_decode(ALUOp_i, funct_i);
  assign is_mul    = (alu_op == AluMul);
  assign mul_idle  = !mul_busy && !mul_done;
  assign mul_start = mul_idle && is_mul && !flush_i;
  assign stall_o   = !flush_i && (mul_busy || (mul_idle && is_mul));

  always_comb begin
    alu_res = op_a + op_b;
    case (alu_op)
      AluSub:  alu_res = op_a - op_b;
      AluAnd:  alu_res = op_a & op_b;
      AluOr:   alu_res = op_a | op_b;
      AluXor:  alu_res = op_a ^ op_b;
      AluSll:  alu_res = op_a << op_b[4:0];
      AluSra:  alu_res = 32'($signed(op_a) >>> IMM_i[4:0]);
      default: alu_res = op_a + op_b;
    endcase
  end

  mul_iter u_mul_iter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .abort_i   (flush_i),
    .a_i       (op_a),
    .b_i       (op_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (product)
  );

  always_comb begin
    mul_wb_d  = mul_wb_q;
    mul_mem_d = mul_mem_q;
    mul_rd_d  = mul_rd_q;
    mul_md_d  = mul_md_q;
    if (mul_start) begin
      mul_wb_d  = WB_i;
      mul_mem_d = MEM_i;
      mul_rd_d  = RDaddr_i;
      mul_md_d  = fwd_b;
    end

    wb_d  = WB_i;
    mem_d = MEM_i;
    alu_d = alu_res;
    md_d  = fwd_b;
    rd_d  = RDaddr_i;
    if (flush_i || stall_o) begin
      wb_d  = '0;
      mem_d = '0;
      alu_d = '0;
      md_d  = '0;
      rd_d  = '0;
    end else if (mul_done) begin
      wb_d  = mul_wb_q;
      mem_d = mul_mem_q;
      alu_d = product;
      md_d  = mul_md_q;
      rd_d  = mul_rd_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_q      <= '0;
      mem_q     <= '0;
      alu_q     <= '0;
      md_q      <= '0;
      rd_q      <= '0;
      mul_wb_q  <= '0;
      mul_mem_q <= '0;
      mul_rd_q  <= '0;
      mul_md_q  <= '0;
    end else begin
      wb_q      <= wb_d;
      mem_q     <= mem_d;
      alu_q     <= alu_d;
      md_q      <= md_d;
      rd_q      <= rd_d;
      mul_wb_q  <= mul_wb_d;
      mul_mem_q <= mul_mem_d;
      mul_rd_q  <= mul_rd_d;
      mul_md_q  <= mul_md_d;
    end
  end

  assign WB_o      = wb_q;
  assign MEM_o     = mem_q;
  assign ALUres_o  = alu_q;
  assign MemData_o = md_q;
  assign RDaddr_o  = rd_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized and directed bench for ex_mem_stage against a cycle-level
// behavioural model of the EX/MEM register contents and the stall output.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst;
  logic [1:0]  wb_in;
  logic [2:0]  mem_in;
  logic        alusrc;
  logic [1:0]  aluop;
  logic [9:0]  funct;
  logic [31:0] rs1, rs2, imm;
  logic [4:0]  rs1a, rs2a, rda;
  logic        mw_we;
  logic [4:0]  mw_rd;
  logic [31:0] mw_data;
  logic        flush;
  logic [1:0]  wb_out;
  logic [2:0]  mem_out;
  logic [31:0] alu_out, md_out;
  logic [4:0]  rd_out;
  logic        stall_o;

  ex_mem_stage dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .WB_i             (wb_in),
    .MEM_i            (mem_in),
    .ALUSrc_i         (alusrc),
    .ALUOp_i          (aluop),
    .funct_i          (funct),
    .RS1_i            (rs1),
    .RS2_i            (rs2),
    .IMM_i            (imm),
    .RS1addr_i        (rs1a),
    .RS2addr_i        (rs2a),
    .RDaddr_i         (rda),
    .MEMWB_RegWrite_i (mw_we),
    .MEMWB_RDaddr_i   (mw_rd),
    .MEMWB_data_i     (mw_data),
    .flush_i          (flush),
    .WB_o             (wb_out),
    .MEM_o            (mem_out),
    .ALUres_o         (alu_out),
    .MemData_o        (md_out),
    .RDaddr_o         (rd_out),
    .stall_o          (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: expected EX/MEM contents, and cycles elapsed since a multiply was accepted.
  logic [1:0]  m_wb;
  logic [2:0]  m_mem;
  logic [31:0] m_alu, m_md;
  logic [4:0]  m_rd;
  int          m_age;
  logic [1:0]  p_wb;
  logic [2:0]  p_mem;
  logic [4:0]  p_rd;
  logic [31:0] p_prod, p_md;
  logic        last_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] ad, input logic [31:0] v);
    if (m_wb[0] && m_rd != 0 && m_rd == ad && !m_mem[0]) return m_alu;
    if (mw_we && mw_rd != 0 && mw_rd == ad) return mw_data;
    return v;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [9:0] f,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] im);
    logic [31:0] r;
    r = a + b;
    if (op == 2'b01) r = a - b;
    else if (op == 2'b10) begin
      if (f == 10'h100) r = a - b;
      else if (f == 10'h007) r = a & b;
      else if (f == 10'h006) r = a | b;
      else if (f == 10'h004) r = a ^ b;
      else if (f == 10'h001) r = a << b[4:0];
    end else if (op == 2'b11 && f == 10'h105) begin
      r = 32'($signed(a) >>> im[4:0]);
    end
    return r;
  endfunction

  task automatic clear_in();
    rst = 0; wb_in = 0; mem_in = 0; alusrc = 0; aluop = 0; funct = 0;
    rs1 = 0; rs2 = 0; imm = 0; rs1a = 0; rs2a = 0; rda = 0;
    mw_we = 0; mw_rd = 0; mw_data = 0; flush = 0;
  endtask

  task automatic model_reset();
    m_wb = 0; m_mem = 0; m_alu = 0; m_md = 0; m_rd = 0; m_age = 0;
    p_wb = 0; p_mem = 0; p_rd = 0; p_prod = 0; p_md = 0;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [9:0] f, input logic src,
                           input logic [4:0] a1, input logic [31:0] v1,
                           input logic [4:0] a2, input logic [31:0] v2,
                           input logic [31:0] im, input logic [4:0] rd,
                           input logic [1:0] wb, input logic [2:0] mem);
    aluop = op; funct = f; alusrc = src; rs1a = a1; rs1 = v1; rs2a = a2; rs2 = v2;
    imm = im; rda = rd; wb_in = wb; mem_in = mem;
  endtask

  task automatic step();
    logic [31:0] a, b, bsel;
    logic        is_mul, exp_stall;
    logic [1:0]  n_wb;
    logic [2:0]  n_mem;
    logic [31:0] n_alu, n_md;
    logic [4:0]  n_rd;
    int          n_age;
    #1;
    a = fwd(rs1a, rs1);
    b = fwd(rs2a, rs2);
    bsel = alusrc ? imm : b;
    is_mul = (aluop == 2'b10 && funct == 10'h008);
    exp_stall = !flush && ((m_age >= 1 && m_age <= 32) || (m_age == 0 && is_mul));
    chk("stall", {31'd0, stall_o}, {31'd0, exp_stall});
    last_stall = stall_o;
    n_wb = 0; n_mem = 0; n_alu = 0; n_md = 0; n_rd = 0; n_age = 0;
    if (rst || flush) begin
      n_age = 0;
    end else if (m_age == 33) begin
      n_wb = p_wb; n_mem = p_mem; n_alu = p_prod; n_md = p_md; n_rd = p_rd;
    end else if (m_age >= 1) begin
      n_age = m_age + 1;
    end else if (is_mul) begin
      n_age = 1;
    end else begin
      n_wb = wb_in; n_mem = mem_in; n_alu = ref_alu(aluop, funct, a, bsel, imm);
      n_md = b; n_rd = rda;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      p_wb = 0; p_mem = 0; p_rd = 0; p_prod = 0; p_md = 0;
    end else if (!flush && m_age == 0 && is_mul) begin
      p_wb = wb_in; p_mem = mem_in; p_rd = rda; p_prod = a * bsel; p_md = b;
    end
    m_wb = n_wb; m_mem = n_mem; m_alu = n_alu; m_md = n_md; m_rd = n_rd; m_age = n_age;
    chk("wb", {30'd0, wb_out}, {30'd0, m_wb});
    chk("mem", {29'd0, mem_out}, {29'd0, m_mem});
    chk("alures", alu_out, m_alu);
    chk("memdata", md_out, m_md);
    chk("rdaddr", {27'd0, rd_out}, {27'd0, m_rd});
  endtask

  task automatic run_mul(input string tag, input logic [31:0] expv);
    int n;
    bit fin;
    n = 0;
    fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      step();
      if (last_stall) n++;
      else fin = 1;
    end
    chk({tag, "_stall_cycles"}, n, 33);
    chk({tag, "_product"}, alu_out, expv);
  endtask

  logic [9:0] ftab [8];

  initial begin
    ftab = '{10'h000, 10'h100, 10'h007, 10'h006, 10'h004, 10'h001, 10'h008, 10'h105};
    clear_in();
    model_reset();
    rst = 1;
    @(posedge clk);
    #1;
    step();
    rst = 0;
    chk("rst_alures", alu_out, 32'd0);
    chk("rst_wb", {30'd0, wb_out}, 32'd0);

    // Plain ADD
    set_instr(2'b10, 10'h000, 0, 5'd1, 32'd5, 5'd2, 32'd7, 0, 5'd3, 2'b01, 3'b000);
    step();
    chk("add_res", alu_out, 32'd12);
    chk("add_rd", {27'd0, rd_out}, 32'd3);

    // Back-to-back dependency, then again with a competing MEM/WB match
    for (int k = 0; k < 2; k++) begin
      set_instr(2'b10, 10'h000, 0, 5'd1, 32'd1, 5'd2, 32'd2, 0, 5'd3, 2'b01, 3'b000);
      mw_we = 0;
      step();
      set_instr(2'b11, 10'h000, 1, 5'd3, 32'd0, 5'd0, 32'd0, 32'd10, 5'd4, 2'b01, 3'b000);
      mw_we = (k == 1); mw_rd = 5'd3; mw_data = 32'd99;
      step();
      chk(k == 0 ? "fwd_exmem" : "fwd_exmem_prio", alu_out, 32'd13);
    end

    // Load in EX/MEM must not forward; MEM/WB or register value is used
    for (int k = 0; k < 2; k++) begin
      clear_in();
      set_instr(2'b00, 10'h000, 1, 5'd0, 32'd0, 5'd0, 32'd0, 32'd100, 5'd5, 2'b11, 3'b001);
      step();
      set_instr(2'b00, 10'h000, 0, 5'd5, 32'd40, 5'd0, 32'd1, 0, 5'd6, 2'b01, 3'b000);
      mw_we = (k == 0); mw_rd = 5'd5; mw_data = 32'd77;
      step();
      chk(k == 0 ? "load_nofwd_mw" : "load_nofwd_rf", alu_out, k == 0 ? 32'd78 : 32'd41);
    end

    // Long multiply, then a back-to-back multiply
    clear_in();
    set_instr(2'b10, 10'h008, 0, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd3, 0, 5'd7, 2'b01, 3'b000);
    run_mul("mul1", 32'hFFFF_FFFD);
    set_instr(2'b10, 10'h008, 0, 5'd1, 32'd2, 5'd2, 32'd3, 0, 5'd8, 2'b01, 3'b000);
    run_mul("mul2", 32'd6);

    // Flush at counter 10
    clear_in();
    set_instr(2'b10, 10'h008, 0, 5'd1, 32'd7, 5'd2, 32'd6, 0, 5'd9, 2'b01, 3'b000);
    repeat (11) step();
    flush = 1;
    #1;
    chk("flush_stall", {31'd0, stall_o}, 32'd0);
    step();
    chk("flush_wb", {30'd0, wb_out}, 32'd0);
    chk("flush_mem", {29'd0, mem_out}, 32'd0);
    clear_in();
    set_instr(2'b10, 10'h000, 0, 5'd1, 32'd2, 5'd2, 32'd2, 0, 5'd10, 2'b01, 3'b000);
    step();
    chk("post_flush_add", alu_out, 32'd4);

    // Reset mid-multiply, then SRA
    set_instr(2'b10, 10'h008, 0, 5'd1, 32'd9, 5'd2, 32'd9, 0, 5'd11, 2'b01, 3'b100);
    repeat (6) step();
    rst = 1;
    step();
    clear_in();
    chk("midrst_alures", alu_out, 32'd0);
    #1;
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    set_instr(2'b11, 10'h105, 1, 5'd1, 32'h8000_0000, 5'd0, 32'd0, 32'd4, 5'd12, 2'b01, 3'b000);
    step();
    chk("sra", alu_out, 32'hF800_0000);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      flush   = ($urandom_range(0, 29) == 0);
      aluop   = 2'($urandom_range(0, 3));
      funct   = ftab[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) funct = 10'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        aluop = 2'b10;
        funct = 10'h008;
      end
      alusrc  = 1'($urandom);
      rs1a    = 5'($urandom_range(0, 3));
      rs2a    = 5'($urandom_range(0, 3));
      rda     = 5'($urandom_range(0, 3));
      rs1     = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 40);
      rs2     = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 40);
      imm     = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 40);
      wb_in   = 2'($urandom);
      mem_in  = 3'($urandom);
      mw_we   = 1'($urandom);
      mw_rd   = 5'($urandom_range(0, 3));
      mw_data = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
